// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: video, writer and RAM-command signals of the framebuffer port arbiter
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 6
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_blank;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_data;
    logic              w0_valid;
    logic [ADDR_W-1:0] w0_addr;
    logic [DATA_W-1:0] w0_data;
    logic              w0_ready;
    logic              w1_valid;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w1_data;
    logic              w1_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr, vid_blank, w0_valid, w0_addr, w0_data,
               w1_valid, w1_addr, w1_data, mem_rdata,
        output vid_valid, vid_data, w0_ready, w1_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, vid_blank, w0_valid, w0_addr, w0_data,
               w1_valid, w1_addr, w1_data, mem_rdata,
        input  vid_valid, vid_data, w0_ready, w1_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the framebuffer port; video reads first, writers round-robin (option FBARB_BLANK_ONLY_EN)
module fb_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 6
) (
    input logic               clk,
    input logic               rst,
    fb_port_arbiter_if.slave  bus_io
);
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [2:0]        pipe_q, pipe_d;
    logic              mem_we_q, mem_we_d;
    logic              last_q, last_d;
    logic              wr_ok, g0, g1;

`ifdef FBARB_BLANK_ONLY_EN
    assign wr_ok = bus_io.vid_blank;
`else
    logic unused_blank;
    assign unused_blank = bus_io.vid_blank;
    assign wr_ok = 1'b1;
`endif

    // grant decision: video wins outright, contention goes to the writer that was not served last
    always_comb begin
        g0          = !bus_io.vid_req && wr_ok && bus_io.w0_valid && (!bus_io.w1_valid || last_q);
        g1          = !bus_io.vid_req && wr_ok && bus_io.w1_valid && (!bus_io.w0_valid || !last_q);
        mem_we_d    = g0 || g1;
        mem_addr_d  = bus_io.vid_req ? bus_io.vid_addr : g0 ? bus_io.w0_addr : g1 ? bus_io.w1_addr : mem_addr_q;
        mem_wdata_d = g0 ? bus_io.w0_data : g1 ? bus_io.w1_data : mem_wdata_q;
        last_d      = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
        pipe_d      = {pipe_q[1:0], bus_io.vid_req};
        vid_data_d  = pipe_q[1] ? bus_io.mem_rdata : vid_data_q;
    end

    // command and read-return registers; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            last_q      <= 1'b1;
            pipe_q      <= '0;
            vid_data_q  <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            last_q      <= last_d;
            pipe_q      <= pipe_d;
            vid_data_q  <= vid_data_d;
        end
    end

    assign bus_io.w0_ready  = g0;
    assign bus_io.w1_ready  = g1;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.mem_wdata = mem_wdata_q;
    assign bus_io.vid_valid = pipe_q[2];
    assign bus_io.vid_data  = vid_data_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed table and sequence checks of fb_port_arbiter against a behavioural RAM
module tb_fb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [5:0] ram [0:16383];

    fb_port_arbiter_if bus ();

    fb_port_arbiter dut (.clk(clk), .rst(rst), .bus_io(bus));

    always #5 clk = ~clk;

    // synchronous-read RAM: write takes effect at the edge, read data one clock after the command
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct {
        logic        vr;
        logic [13:0] va;
        logic        v0;
        logic [13:0] a0;
        logic [5:0]  d0;
        logic        v1;
        logic [13:0] a1;
        logic [5:0]  d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [13:0] addr;
        logic [5:0]  wd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.vid_req  = 1'b0;
        bus.vid_addr = '0;
        bus.w0_valid = 1'b0;
        bus.w0_addr  = '0;
        bus.w0_data  = '0;
        bus.w1_valid = 1'b0;
        bus.w1_addr  = '0;
        bus.w1_data  = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int writes;
        int hs;
        int pulses;
        bus.vid_blank = 1'b1;
        idle();
        //          vr  va        v0  a0        d0     v1  a1        d1     r0 r1 we addr      wd
        vecs[0]  = '{0, 14'h0000, 0, 14'h0000, 6'h00, 0, 14'h0000, 6'h00, 0, 0, 0, 14'h0000, 6'h00};
        vecs[1]  = '{0, 14'h0000, 1, 14'h0010, 6'h01, 0, 14'h0000, 6'h00, 1, 0, 1, 14'h0010, 6'h01};
        vecs[2]  = '{0, 14'h0000, 1, 14'h0020, 6'h02, 1, 14'h0030, 6'h03, 0, 1, 1, 14'h0030, 6'h03};
        vecs[3]  = '{0, 14'h0000, 1, 14'h0020, 6'h02, 1, 14'h0030, 6'h03, 1, 0, 1, 14'h0020, 6'h02};
        vecs[4]  = '{0, 14'h0000, 1, 14'h0020, 6'h02, 1, 14'h0030, 6'h03, 0, 1, 1, 14'h0030, 6'h03};
        vecs[5]  = '{0, 14'h0000, 1, 14'h0020, 6'h02, 1, 14'h0030, 6'h03, 1, 0, 1, 14'h0020, 6'h02};
        vecs[6]  = '{1, 14'h0081, 1, 14'h0020, 6'h02, 1, 14'h0030, 6'h03, 0, 0, 0, 14'h0081, 6'h00};
        vecs[7]  = '{0, 14'h0000, 1, 14'h0020, 6'h02, 1, 14'h0030, 6'h03, 0, 1, 1, 14'h0030, 6'h03};
        vecs[8]  = '{0, 14'h0000, 0, 14'h0000, 6'h00, 0, 14'h0000, 6'h00, 0, 0, 0, 14'h0030, 6'h00};
        vecs[9]  = '{0, 14'h0000, 0, 14'h0000, 6'h00, 1, 14'h1FFF, 6'h3F, 0, 1, 1, 14'h1FFF, 6'h3F};
        vecs[10] = '{0, 14'h0000, 0, 14'h0000, 6'h00, 1, 14'h1FFF, 6'h3F, 0, 1, 1, 14'h1FFF, 6'h3F};
        vecs[11] = '{0, 14'h0000, 1, 14'h0020, 6'h02, 1, 14'h1FFF, 6'h3F, 1, 0, 1, 14'h0020, 6'h02};

        do_reset();
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_vid_valid", bus.vid_valid, 0);
        chk("rst_vid_data", bus.vid_data, 0);

        for (int i = 0; i < 12; i++) begin
            bus.vid_req  = vecs[i].vr;
            bus.vid_addr = vecs[i].va;
            bus.w0_valid = vecs[i].v0;
            bus.w0_addr  = vecs[i].a0;
            bus.w0_data  = vecs[i].d0;
            bus.w1_valid = vecs[i].v1;
            bus.w1_addr  = vecs[i].a1;
            bus.w1_data  = vecs[i].d1;
            @(negedge clk);
            chk($sformatf("vec%0d_w0_ready", i), bus.w0_ready, vecs[i].r0);
            chk($sformatf("vec%0d_w1_ready", i), bus.w1_ready, vecs[i].r1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_mem_we", i), bus.mem_we, vecs[i].we);
            chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].addr);
            if (vecs[i].we) chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, vecs[i].wd);
        end

        // load 2A at 0081 through writer 0, then reset and read it back
        idle();
        bus.w0_valid = 1'b1;
        bus.w0_addr  = 14'h0081;
        bus.w0_data  = 6'h2A;
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        do_reset();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 14'h0081;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                bus.vid_req = 1'b0;
                chk("read_cmd_addr", bus.mem_addr, 14'h0081);
                chk("read_cmd_we", bus.mem_we, 0);
            end
            if (bus.vid_valid) begin
                pulses++;
                chk("read_latency", k, 3);
                chk("read_data", bus.vid_data, 6'h2A);
            end
        end
        chk("read_pulses", pulses, 1);

        // video every 4th clock steals the port from a continuously valid w1
        writes = 0;
        hs = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                writes += int'(bus.mem_we);
            end
            bus.vid_req  = (k % 4 == 0);
            bus.w1_valid = 1'b1;
            bus.w1_addr  = 14'h1FFF;
            bus.w1_data  = 6'h3F;
            @(negedge clk);
            chk($sformatf("steal%0d_w1_ready", k), bus.w1_ready, (k % 4 != 0));
            hs += int'(bus.w1_ready);
        end
        @(posedge clk); #1;
        writes += int'(bus.mem_we);
        chk("steal_mem_addr", bus.mem_addr, 14'h1FFF);
        chk("steal_mem_wdata", bus.mem_wdata, 6'h3F);
        idle();
        chk("steal_handshakes", hs, 6);
        chk("steal_writes", writes, 6);

        // write in cycle n, read of the same address in n+1 returns the new word at n+4
        @(posedge clk); #1;
        bus.w0_valid = 1'b1;
        bus.w0_addr  = 14'h0100;
        bus.w0_data  = 6'h15;
        @(negedge clk);
        chk("wr_rd_w0_ready", bus.w0_ready, 1);
        @(posedge clk); #1;
        idle();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 14'h0100;
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
        @(posedge clk); #1;
        chk("wr_rd_early_valid", bus.vid_valid, 0);
        @(posedge clk); #1;
        chk("wr_rd_valid", bus.vid_valid, 1);
        chk("wr_rd_data", bus.vid_data, 6'h15);

        // reset one cycle after a read request, with last grant pointing at w0
        @(posedge clk); #1;
        bus.w0_valid = 1'b1;
        bus.w0_addr  = 14'h0200;
        bus.w0_data  = 6'h07;
        @(posedge clk); #1;
        idle();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 14'h0100;
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_mem_addr", bus.mem_addr, 0);
        chk("mid_rst_mem_we", bus.mem_we, 0);
        chk("mid_rst_mem_wdata", bus.mem_wdata, 0);
        chk("mid_rst_vid_data", bus.vid_data, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("mid_rst_vid_valid%0d", k), bus.vid_valid, 0);
            @(posedge clk); #1;
        end
        bus.w0_valid = 1'b1;
        bus.w0_addr  = 14'h0222;
        bus.w0_data  = 6'h0A;
        bus.w1_valid = 1'b1;
        bus.w1_addr  = 14'h0333;
        bus.w1_data  = 6'h0B;
        @(negedge clk);
        chk("post_rst_w0_ready", bus.w0_ready, 1);
        chk("post_rst_w1_ready", bus.w1_ready, 0);
        @(posedge clk); #1;
        chk("post_rst_mem_addr", bus.mem_addr, 14'h0222);
        idle();

        // writer held off while the visible area is being scanned
        @(posedge clk); #1;
        bus.vid_blank = 1'b0;
        bus.w0_valid  = 1'b1;
        bus.w0_addr   = 14'h0300;
        bus.w0_data   = 6'h11;
`ifdef FBARB_BLANK_ONLY_EN
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("blank%0d_w0_ready", k), bus.w0_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("blank%0d_mem_we", k), bus.mem_we, 0);
        end
        bus.vid_blank = 1'b1;
`endif
        @(negedge clk);
        chk("blank_w0_ready", bus.w0_ready, 1);
        @(posedge clk); #1;
        chk("blank_mem_we", bus.mem_we, 1);
        chk("blank_mem_addr", bus.mem_addr, 14'h0300);
        idle();
        bus.vid_blank = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single synchronous-read framebuffer port (128x128 words, 6-bit palette indices) between the video scanout reader and two pixel writers: w0 is the host loader, w1 is the blitter.
- Video reads have absolute priority. Writers are round-robin arbitrated into the remaining cycles.
- Sits between the video timing/palette path and the framebuffer RAM. It drives every RAM command from registers.

Parameters:
- ADDR_W, 14, framebuffer address width; address = {y[6:0], x[6:0]}
- DATA_W, 6, framebuffer word width (palette index)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- vid_req  in  1  one-cycle video read request
- vid_addr  in  ADDR_W  video read address, sampled with vid_req
- vid_blank  in  1  high outside the visible area; used only under the optional feature
- vid_valid  out  1  one-cycle pulse: vid_data holds the requested word
- vid_data  out  DATA_W  video read data
- w0_valid  in  1  writer 0 request
- w0_addr  in  ADDR_W  writer 0 address
- w0_data  in  DATA_W  writer 0 data
- w0_ready  out  1  writer 0 grant; a transfer occurs when valid & ready
- w1_valid, w1_addr, w1_data, w1_ready: same as w0, for writer 1
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid one clock after the read command is presented

Behaviour:
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, vid_valid=0, vid_data=0. Internal last_grant=1, so w0 wins the first contention.
- The port carries one command per clock. The decision in cycle n is registered onto mem_* at the end of cycle n.
- Priority in cycle n:
  - vid_req=1: issue a read of vid_addr (mem_we=0); w0_ready=w1_ready=0.
  - Else, exactly one writer valid: grant it.
  - Else, both writers valid: grant the writer != last_grant.
  - Else: idle. mem_we=0; mem_addr holds its previous value.
- Ready signals are combinational from vid_req, w*_valid and last_grant. At most one ready is high per cycle. Ready is never asserted for a writer whose valid is low.
- On a writer grant: mem_addr<=wX_addr, mem_wdata<=wX_data, mem_we<=1, last_grant<=X. last_grant changes only on a writer grant.
- Video read pipeline, for vid_req in cycle n:
  - n+1: command on mem_*.
  - n+2: mem_rdata valid.
  - n+3: vid_data registered, vid_valid=1.
  - Fixed latency of 3 clocks, so a read completes inside one 4-clock pixel period.
- A 3-deep valid shift register tracks in-flight reads. Back-to-back vid_req on consecutive cycles is legal and produces back-to-back vid_valid pulses in order.
- Writer stall: a writer holding valid with stable addr/data must not change them until ready. It waits indefinitely while vid_req is high.
- Write then read of the same address: a write accepted in cycle n followed by vid_req in cycle n+1 returns the new data (RAM has write-before-next-read ordering).
- Reset mid-operation: in-flight video reads are discarded (no vid_valid after reset). mem_we drops to 0 on the reset edge, and last_grant returns to 1.
- vid_data holds its last value between vid_valid pulses.

Optional Feature:
- Macro: FBARB_BLANK_ONLY_EN
- Defined: writers are granted only when vid_blank=1 in the same cycle. With vid_blank=0, w0_ready=w1_ready=0 even on idle cycles, which prevents visible tearing. Video read behaviour is unchanged.
- Undefined: vid_blank is ignored; writers use every cycle without vid_req.

Test Plan:
- Reset, then vid_req with vid_addr=14'h0081 and RAM word 6'h2A -> mem_addr=14'h0081 with mem_we=0 one clock later; vid_valid=1 and vid_data=6'h2A exactly 3 clocks after the request; no other vid_valid pulse.
- w0 and w1 both valid continuously, no vid_req, 4 cycles -> grants alternate w0,w1,w0,w1; mem_we=1 each cycle; mem_addr/mem_wdata match the granted writer.
- vid_req pulsed every 4th clock while w1 is valid with addr 14'h1FFF and data 6'h3F -> w1_ready=0 on the request cycles and 1 on the other three; exactly one write per accepted handshake.
- w0 writes 6'h15 to 14'h0100 in cycle n; vid_req to 14'h0100 in cycle n+1 -> vid_data=6'h15 at cycle n+4.
- rst asserted for 1 clock, 1 cycle after vid_req -> no vid_valid afterwards; all outputs return to reset values; next contention grants w0.
- With FBARB_BLANK_ONLY_EN: w0 valid, vid_blank=0 for 10 clocks -> w0_ready stays 0. vid_blank rises -> write issued that cycle. Without the macro, the write is issued in the first cycle.
